// File: rtl/lru_cache_controller.sv
// lru_cache_controller: request sequencer and tag/data storage for one 8-way fully
// associative cache set, with write-back, refill and LRU-matrix update handshakes.
module lru_cache_controller #(
    parameter int TAG_W  = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [TAG_W-1:0]  req_tag,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_hit,
    output logic [2:0]        resp_way,
    output logic [DATA_W-1:0] resp_data,
    output logic              mem_wb_valid,
    input  logic              mem_wb_ready,
    output logic [TAG_W-1:0]  mem_wb_tag,
    output logic [DATA_W-1:0] mem_wb_data,
    output logic              mem_rd_valid,
    input  logic              mem_rd_ready,
    output logic [TAG_W-1:0]  mem_rd_tag,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic [2:0]        lru_way,
    output logic [2:0]        lru_line_index,
    output logic              lru_hit,
    output logic              lru_update,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [TAG_W-1:0]  tags [8];
    logic [DATA_W-1:0] data [8];
    logic [7:0]        valid, dirty;
    logic              cap_we;
    logic [TAG_W-1:0]  cap_tag;
    logic [DATA_W-1:0] cap_wdata;
    logic [2:0]        victim, hit_way, inv_way, pick;
    logic              hit, any_inv, look_hit, fill_done;
    logic              resp_hit_r;
    logic [2:0]        resp_way_r;
    logic [DATA_W-1:0] resp_data_r;

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        any_inv = 1'b0;
        inv_way = '0;
        for (int i = 7; i >= 0; i--) begin
            if (valid[i] && tags[i] == cap_tag) begin
                hit = 1'b1;
                hit_way = 3'(i);
            end
            if (!valid[i]) begin
                any_inv = 1'b1;
                inv_way = 3'(i);
            end
        end
        pick = any_inv ? inv_way : lru_way;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      state_nx = req_valid ? LOOKUP : IDLE;
            LOOKUP:    state_nx = hit ? RESP : (valid[pick] && dirty[pick]) ? WB : FILL_REQ;
            WB:        state_nx = mem_wb_ready ? FILL_REQ : WB;
            FILL_REQ:  state_nx = mem_rd_ready ? FILL_WAIT : FILL_REQ;
            FILL_WAIT: state_nx = mem_rsp_valid ? RESP : FILL_WAIT;
            RESP:      state_nx = resp_ready ? IDLE : RESP;
            default:   state_nx = IDLE;
        endcase
    end

    assign look_hit       = state == LOOKUP && hit;
    assign fill_done      = state == FILL_WAIT && mem_rsp_valid;
    assign req_ready      = state == IDLE;
    assign resp_valid     = state == RESP;
    assign resp_hit       = resp_hit_r;
    assign resp_way       = resp_way_r;
    assign resp_data      = resp_data_r;
    assign mem_wb_valid   = state == WB;
    assign mem_wb_tag     = mem_wb_valid ? tags[victim] : '0;
    assign mem_wb_data    = mem_wb_valid ? data[victim] : '0;
    assign mem_rd_valid   = state == FILL_REQ;
    assign mem_rd_tag     = mem_rd_valid ? cap_tag : '0;
    assign lru_update     = look_hit || fill_done;
    assign lru_hit        = lru_update;
    assign lru_line_index = look_hit ? hit_way : fill_done ? victim : 3'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid       <= '0;
            dirty       <= '0;
            cap_we      <= 1'b0;
            cap_tag     <= '0;
            cap_wdata   <= '0;
            victim      <= '0;
            resp_hit_r  <= 1'b0;
            resp_way_r  <= '0;
            resp_data_r <= '0;
            hit_count   <= '0;
            miss_count  <= '0;
            for (int i = 0; i < 8; i++) begin
                tags[i] <= '0;
                data[i] <= '0;
            end
        end else begin
            if (req_valid && req_ready) begin
                cap_we    <= req_we;
                cap_tag   <= req_tag;
                cap_wdata <= req_wdata;
            end
            if (look_hit) begin
                if (cap_we) begin
                    data[hit_way]  <= cap_wdata;
                    dirty[hit_way] <= 1'b1;
                end
                resp_hit_r  <= 1'b1;
                resp_way_r  <= hit_way;
                resp_data_r <= cap_we ? cap_wdata : data[hit_way];
                if (~&hit_count) hit_count <= hit_count + 1'b1;
            end
            if (state == LOOKUP && !hit) begin
                victim <= pick;
                if (~&miss_count) miss_count <= miss_count + 1'b1;
            end
            if (state == WB && mem_wb_ready) dirty[victim] <= 1'b0;
            if (fill_done) begin
                tags[victim]  <= cap_tag;
                valid[victim] <= 1'b1;
                data[victim]  <= cap_we ? cap_wdata : mem_rsp_data;
                dirty[victim] <= cap_we;
                resp_hit_r    <= 1'b0;
                resp_way_r    <= victim;
                resp_data_r   <= cap_we ? cap_wdata : mem_rsp_data;
            end
        end
    end
endmodule

// File: tb/tb_lru_cache_controller.sv
// tb_lru_cache_controller: directed and random requests checked against a way-array model,
// with the bench acting as both backing memory and a true-LRU recency list.
module tb_lru_cache_controller;
    localparam int TAG_W = 8, DATA_W = 8, CNT_W = 5;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 1'b0, reset = 1'b0;
    logic req_valid = 0, req_ready, req_we = 0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic resp_valid, resp_ready = 0, resp_hit;
    logic [2:0] resp_way;
    logic [DATA_W-1:0] resp_data;
    logic mem_wb_valid, mem_wb_ready = 0;
    logic [TAG_W-1:0] mem_wb_tag;
    logic [DATA_W-1:0] mem_wb_data;
    logic mem_rd_valid, mem_rd_ready = 0;
    logic [TAG_W-1:0] mem_rd_tag;
    logic mem_rsp_valid = 0;
    logic [DATA_W-1:0] mem_rsp_data = '0;
    logic [2:0] lru_way = '0, lru_line_index;
    logic lru_hit, lru_update;
    logic [CNT_W-1:0] hit_count, miss_count;

    always #5 clk = ~clk;

    lru_cache_controller #(.TAG_W(TAG_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_tag(req_tag), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_data(resp_data),
        .mem_wb_valid(mem_wb_valid), .mem_wb_ready(mem_wb_ready),
        .mem_wb_tag(mem_wb_tag), .mem_wb_data(mem_wb_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_tag(mem_rd_tag),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .lru_way(lru_way), .lru_line_index(lru_line_index), .lru_hit(lru_hit),
        .lru_update(lru_update), .hit_count(hit_count), .miss_count(miss_count)
    );

    int n_checks = 0, n_fail = 0;
    logic [TAG_W-1:0] m_tag [8];
    logic [DATA_W-1:0] m_data [8];
    bit m_valid [8], m_dirty [8];
    int lru_q [$];
    logic [DATA_W-1:0] backing [256];
    int m_hits = 0, m_misses = 0;
    int force_lru = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        lru_q = {0, 1, 2, 3, 4, 5, 6, 7};
        m_hits = 0;
        m_misses = 0;
    endfunction

    function automatic void touch(input int w);
        int idx [$];
        idx = lru_q.find_first_index(x) with (x == w);
        if (idx.size() > 0) lru_q.delete(idx[0]);
        lru_q.push_back(w);
    endfunction

    function automatic int min_sat(input int v);
        return v > CMAX ? CMAX : v;
    endfunction

    task automatic check_counters();
        chk("hit_count", 32'(hit_count), min_sat(m_hits));
        chk("miss_count", 32'(miss_count), min_sat(m_misses));
    endtask

    task automatic do_req(input bit we, input logic [7:0] tag, input logic [7:0] wd,
                          input int wb_stall, input int rd_stall, input int rsp_stall,
                          input int hold, input bit abort);
        int way, cyc, exp_lat;
        bit hit, exp_wb;
        logic [7:0] exp_data;
        hit = 0;
        way = -1;
        exp_wb = 0;
        for (int i = 0; i < 8; i++)
            if (!hit && m_valid[i] && m_tag[i] == tag) begin
                hit = 1;
                way = i;
            end
        chk("req_ready_idle", 32'(req_ready), 1);
        lru_way = 3'(force_lru >= 0 ? force_lru : lru_q[0]);
        req_valid = 1;
        req_we = we;
        req_tag = tag;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 0;
        cyc = 1;
        chk("req_ready_busy", 32'(req_ready), 0);
        chk("lookup_no_wb", 32'(mem_wb_valid), 0);
        chk("lookup_no_rd", 32'(mem_rd_valid), 0);
        if (hit) begin
            chk("hit_upd", 32'(lru_update), 1);
            chk("hit_lru_hit", 32'(lru_hit), 1);
            chk("hit_idx", 32'(lru_line_index), way);
            if (we) begin
                m_data[way] = wd;
                m_dirty[way] = 1;
            end
            m_hits++;
            touch(way);
            @(negedge clk);
            cyc++;
        end else begin
            chk("miss_no_upd", 32'(lru_update), 0);
            m_misses++;
            for (int i = 0; i < 8; i++) if (way < 0 && !m_valid[i]) way = i;
            if (way < 0) way = int'(lru_way);
            exp_wb = m_valid[way] && m_dirty[way];
            @(negedge clk);
            cyc++;
            if (exp_wb) begin
                for (int s = 0; s <= wb_stall; s++) begin
                    chk("wb_valid", 32'(mem_wb_valid), 1);
                    chk("wb_tag", 32'(mem_wb_tag), 32'(m_tag[way]));
                    chk("wb_data", 32'(mem_wb_data), 32'(m_data[way]));
                    chk("wb_no_rd", 32'(mem_rd_valid), 0);
                    mem_wb_ready = (s == wb_stall);
                    @(negedge clk);
                    cyc++;
                end
                mem_wb_ready = 0;
                backing[m_tag[way]] = m_data[way];
                m_dirty[way] = 0;
            end
            for (int s = 0; s <= rd_stall; s++) begin
                chk("rd_valid", 32'(mem_rd_valid), 1);
                chk("rd_tag", 32'(mem_rd_tag), 32'(tag));
                chk("rd_no_wb", 32'(mem_wb_valid), 0);
                chk("rd_no_upd", 32'(lru_update), 0);
                mem_rd_ready = (s == rd_stall);
                @(negedge clk);
                cyc++;
            end
            mem_rd_ready = 0;
            if (abort) begin
                reset = 0;
                model_reset();
                #1;
                chk("abort_ready", 32'(req_ready), 1);
                chk("abort_resp", 32'(resp_valid), 0);
                chk("abort_rd", 32'(mem_rd_valid), 0);
                check_counters();
                @(negedge clk);
                reset = 1;
                mem_rsp_valid = 1;
                mem_rsp_data = 8'hEE;
                #1;
                chk("late_rsp_no_upd", 32'(lru_update), 0);
                @(negedge clk);
                mem_rsp_valid = 0;
                chk("late_rsp_resp", 32'(resp_valid), 0);
                chk("late_rsp_ready", 32'(req_ready), 1);
                check_counters();
                return;
            end
            for (int s = 0; s < rsp_stall; s++) begin
                chk("wait_no_upd", 32'(lru_update), 0);
                chk("wait_no_resp", 32'(resp_valid), 0);
                @(negedge clk);
                cyc++;
            end
            mem_rsp_valid = 1;
            mem_rsp_data = backing[tag];
            #1;
            chk("fill_upd", 32'(lru_update), 1);
            chk("fill_lru_hit", 32'(lru_hit), 1);
            chk("fill_idx", 32'(lru_line_index), way);
            m_tag[way] = tag;
            m_valid[way] = 1;
            m_data[way] = we ? wd : backing[tag];
            m_dirty[way] = we;
            touch(way);
            @(negedge clk);
            mem_rsp_valid = 0;
            cyc++;
        end
        exp_data = m_data[way];
        exp_lat = hit ? 2 : 4 + rd_stall + rsp_stall + (exp_wb ? wb_stall + 1 : 0);
        chk("latency", cyc, exp_lat);
        for (int h = 0; h <= hold; h++) begin
            chk("resp_valid", 32'(resp_valid), 1);
            chk("resp_hit", 32'(resp_hit), 32'(hit));
            chk("resp_way", 32'(resp_way), way);
            chk("resp_data", 32'(resp_data), 32'(exp_data));
            chk("resp_req_ready", 32'(req_ready), 0);
            chk("resp_no_upd", 32'(lru_update), 0);
            chk("resp_no_mem", 32'(mem_wb_valid | mem_rd_valid), 0);
            resp_ready = (h == hold);
            @(negedge clk);
        end
        resp_ready = 0;
        chk("resp_done", 32'(resp_valid), 0);
        chk("back_idle", 32'(req_ready), 1);
        check_counters();
    endtask

    initial begin
        for (int t = 0; t < 256; t++) backing[t] = 8'($urandom);
        backing[8'h11] = 8'hA5;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_resp", 32'(resp_valid), 0);
        chk("rst_upd", 32'(lru_update | lru_hit), 0);
        chk("rst_mem", 32'(mem_wb_valid | mem_rd_valid), 0);
        check_counters();
        reset = 1;
        @(negedge clk);
        do_req(0, 8'h11, 8'h00, 0, 0, 0, 0, 0);
        do_req(0, 8'h11, 8'h00, 0, 0, 0, 0, 0);
        do_req(0, 8'h22, 8'h00, 0, 1, 2, 0, 1);
        for (int t = 1; t <= 8; t++) do_req(0, 8'(t), 8'h00, 0, 0, 0, 0, 0);
        force_lru = 3;
        do_req(0, 8'h09, 8'h00, 0, 0, 0, 0, 0);
        do_req(1, 8'h02, 8'h3C, 0, 0, 0, 5, 0);
        force_lru = 1;
        do_req(0, 8'h0A, 8'h00, 3, 0, 0, 0, 0);
        force_lru = -1;
        for (int n = 0; n < 150; n++)
            do_req(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom),
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom_range(0, 2), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/lru_cache_controller.md
Name: lru_cache_controller

Overview:
- Sequencing controller for one 8-way fully associative cache set whose replacement state lives in the 8x8 LRU matrix.
- Holds the tag, valid, dirty and data storage for each way.
- Accepts one request at a time over a valid/ready handshake and performs the lookup.
- On a miss it chooses a victim, writes back a dirty victim, refills from memory, and drives the LRU update strobe and way index.

Parameters:
- TAG_W, 8, request/line tag width.
- DATA_W, 8, one data word per line.
- CNT_W, 16, width of hit/miss statistic counters.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1=write, 0=read.
- req_tag  in  TAG_W  request tag.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response available.
- resp_ready  in  1  requester consumes the response.
- resp_hit  out  1  request hit.
- resp_way  out  3  way that served the request.
- resp_data  out  DATA_W  line data after the access.
- mem_wb_valid  out  1  write-back request.
- mem_wb_ready  in  1  memory accepts the write-back.
- mem_wb_tag  out  TAG_W  victim tag.
- mem_wb_data  out  DATA_W  victim data.
- mem_rd_valid  out  1  refill read request.
- mem_rd_ready  in  1  memory accepts the read.
- mem_rd_tag  out  TAG_W  refill tag.
- mem_rsp_valid  in  1  refill data returned.
- mem_rsp_data  in  DATA_W  refill data.
- lru_way  in  3  current least-recently-used way from the LRU matrix.
- lru_line_index  out  3  way to mark most-recently-used.
- lru_hit  out  1  select lru_line_index at the LRU matrix.
- lru_update  out  1  one-cycle strobe; the LRU matrix samples within that cycle.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE; all valid/dirty bits clear; counters 0.
  - All outputs 0 except req_ready=1 once in IDLE.
  - Any in-flight memory transaction is abandoned: no retry, and a late mem_rsp_valid is ignored.
- FSM states: IDLE, LOOKUP, WB, FILL_REQ, FILL_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: capture we/tag/wdata, go to LOOKUP.
- LOOKUP (exactly 1 cycle), hit (a valid way has a matching tag):
  - For a write: data<=wdata, dirty<=1.
  - lru_update=1, lru_line_index=hit way, lru_hit=1.
  - hit_count++, go to RESP with resp_hit=1.
- LOOKUP, miss:
  - miss_count++.
  - Victim = lowest-index invalid way if any, else lru_way sampled this cycle.
  - Victim valid&dirty -> WB, else -> FILL_REQ.
- WB:
  - mem_wb_valid=1 with the victim tag/data, held stable until mem_wb_ready.
  - On handshake: victim dirty<=0, go to FILL_REQ.
- FILL_REQ:
  - mem_rd_valid=1, mem_rd_tag=captured tag.
  - On mem_rd_ready go to FILL_WAIT.
- FILL_WAIT:
  - On mem_rsp_valid: victim tag<=captured tag, valid<=1.
  - Victim data<=(we ? wdata : mem_rsp_data); dirty<=we.
  - lru_update=1, lru_line_index=victim, lru_hit=1.
  - Go to RESP with resp_hit=0.
- RESP:
  - resp_valid=1 with resp_hit/resp_way/resp_data registered, held until resp_ready.
  - Then go to IDLE; req_ready is re-asserted in the next cycle, with no back-to-back accept in the same cycle.
- lru_update is 0 in every state and cycle other than the two listed above.
- Latency:
  - Hit: request accepted at cycle 0, resp_valid at cycle 2.
  - Clean miss with zero-wait memory (ready and rsp the cycle after each request): resp_valid at cycle 4.
  - Dirty miss adds 1 cycle plus mem_wb_ready wait.
- Counters saturate at all-ones and never wrap.
- mem_rsp_valid outside FILL_WAIT is ignored.
- req_valid while not in IDLE is not accepted; req_ready=0.
- Duplicate tags never arise, because fills occur only on a miss.

Test Plan:
- Reset, then read tag 0x11 -> miss.
  - mem_rd_tag=0x11; memory returns 0xA5.
  - resp_hit=0, resp_way=0, resp_data=0xA5, miss_count=1, one lru_update with index 0.
- Read 0x11 again -> hit.
  - resp_valid 2 cycles after accept; resp_hit=1, resp_way=0, resp_data=0xA5.
  - lru_update with index 0; hit_count=1; no mem_* activity.
- Fill tags 0x01..0x08 (ways 0..7), then read 0x09 with lru_way=3.
  - Victim is way 3; no write-back (clean).
  - Fill installs 0x09 at way 3; lru_update index 3.
- Write 0x02 data 0x3C (hit, dirty), force lru_way=1, read 0x0A.
  - mem_wb_valid with tag 0x02, data 0x3C, held through 3 cycles of mem_wb_ready=0.
  - Then mem_rd_tag=0x0A.
- Assert reset during FILL_WAIT, then drive mem_rsp_valid.
  - Ignored; all lines invalid, counters 0, req_ready=1, resp_valid=0.
- Hold resp_ready=0 for 5 cycles in RESP.
  - resp_valid and response fields stable throughout; req_ready=0 throughout.
  - IDLE on the cycle after resp_ready=1.
